// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t   : ownership state of the arbiter FSM
//   PORT_C/PORT_D : winner index (core load/store port, debug/loader port)
//   BURST_MAX_DEF : default number of consecutive grants before handing over
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned BURST_MAX_DEF = 4;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Burst-fair ownership FSM for the two data-memory requesters.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   c_req, d_req   : request from core port / debug port
//   gnt_c, gnt_d   : combinational grant, at most one per cycle, 0 during reset
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic c_req,
  input  logic d_req,
  output logic gnt_c,
  output logic gnt_d
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  arb_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          own_is_c;
  logic          own_req;
  logic          oth_req;
  logic          burst_done;

  // State and burst-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Winner selection; owner/other are folded so OWN_C and OWN_D share one path
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    gnt_c      = 1'b0;
    gnt_d      = 1'b0;
    own_is_c   = (state == OWN_C);
    own_req    = own_is_c ? c_req : d_req;
    oth_req    = own_is_c ? d_req : c_req;
    burst_done = (cnt == CW'(BURST_MAX));

    if (!rst) begin
      case (state)
        IDLE: begin
          if (c_req) begin
            gnt_c   = 1'b1;
            state_n = OWN_C;
            cnt_n   = CW'(1);
          end else if (d_req) begin
            gnt_d   = 1'b1;
            state_n = OWN_D;
            cnt_n   = CW'(1);
          end
        end

        OWN_C, OWN_D: begin
          if (own_req && (!burst_done || !oth_req)) begin
            gnt_c = own_is_c;
            gnt_d = !own_is_c;
            // count saturates so a lone owner never wraps back under the limit
            if (!burst_done) begin
              cnt_n = cnt + CW'(1);
            end
          end else if (oth_req) begin
            gnt_c   = !own_is_c;
            gnt_d   = own_is_c;
            state_n = own_is_c ? OWN_D : OWN_C;
            cnt_n   = CW'(1);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end

        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core load/store path (C)
// and a debug/loader port (D).
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata    : core request (held until c_gnt)
//   d_req/d_we/d_addr/d_wdata    : debug request (held until d_gnt)
//   c_gnt, d_gnt                 : combinational grant
//   c_rvalid, d_rvalid           : one-cycle pulse after a granted read
//   c_rdata, d_rdata             : registered read data, held until next read
//   core_stall                   : core requested but was not granted
//   mem_we, mem_a, mem_wd        : memory write enable, address, write data
//   mem_rd                       : memory read data (combinational from mem_a)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          c_gnt,
  output logic          d_gnt,
  output logic          c_rvalid,
  output logic          d_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic [DW-1:0] d_rdata,
  output logic          core_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  logic win_sel;
  logic win_we;
  logic c_rd_hit;
  logic d_rd_hit;

  dmem_arb_fsm #(
    .BURST_MAX (BURST_MAX)
  ) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .c_req (c_req),
    .d_req (d_req),
    .gnt_c (c_gnt),
    .gnt_d (d_gnt)
  );

  // Memory mux; port C drives the bus when nobody is granted
  always_comb begin
    win_sel    = d_gnt ? PORT_D : PORT_C;
    win_we     = (win_sel == PORT_D) ? d_we : c_we;
    mem_a      = (win_sel == PORT_D) ? d_addr : c_addr;
    mem_wd     = (win_sel == PORT_D) ? d_wdata : c_wdata;
    mem_we     = win_we & (c_gnt | d_gnt);
    core_stall = c_req & ~c_gnt;
    c_rd_hit   = c_gnt & ~c_we;
    d_rd_hit   = d_gnt & ~d_we;
  end

  // Read-return registers; reset also cancels a pending rvalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_rd_hit;
      d_rvalid <= d_rd_hit;
      if (c_rd_hit) begin
        c_rdata <= mem_rd;
      end
      if (d_rd_hit) begin
        d_rdata <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter.
// Stimulus queues the expected per-cycle handshake vector and expected read
// data; monitors pop and compare at the falling edge.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BM = 4;

  logic          clk;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, d_gnt, c_rvalid, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          core_stall, mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;

  logic [31:0]   mem [0:63];
  logic          mem_init = 1'b0;

  int unsigned   vectors;
  int unsigned   miscompares;
  int unsigned   cyc_no;

  // expected {c_gnt, d_gnt, core_stall, mem_we, c_rvalid, d_rvalid}
  logic [5:0]    cyc_q [$];
  logic [31:0]   crd_q [$];
  logic [31:0]   drd_q [$];
  logic [5:0]    mon_exp, mon_got;
  logic [31:0]   rd_exp;

  dmem_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .BURST_MAX (BM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .c_req      (c_req),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .c_gnt      (c_gnt),
    .d_gnt      (d_gnt),
    .c_rvalid   (c_rvalid),
    .d_rvalid   (d_rvalid),
    .c_rdata    (c_rdata),
    .d_rdata    (d_rdata),
    .core_stall (core_stall),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-word memory model: word i preloads to {A5A5, i}, word 4 (0x10) to DEADBEEF
  assign mem_rd = (mem_a < 32'd256) ? mem[mem_a[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= {16'hA5A5, 16'(i)};
      mem[4]   <= 32'hDEAD_BEEF;
      mem_init <= 1'b1;
    end else if (mem_we && mem_a < 32'd256) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  // Monitor: handshake vector and read-return scoreboard
  always @(negedge clk) begin
    cyc_no++;
    if (cyc_q.size() > 0) begin
      mon_exp = cyc_q.pop_front();
      mon_got = {c_gnt, d_gnt, core_stall, mem_we, c_rvalid, d_rvalid};
      vectors++;
      if (mon_got !== mon_exp) begin
        miscompares++;
        $display("FAIL handshake cyc %0d {c_gnt,d_gnt,stall,we,c_rv,d_rv}: got %b expected %b",
                 cyc_no, mon_got, mon_exp);
      end
    end
    if (c_rvalid) begin
      vectors++;
      if (crd_q.size() == 0) begin
        miscompares++;
        $display("FAIL c_rvalid cyc %0d: got unexpected pulse, expected none", cyc_no);
      end else begin
        rd_exp = crd_q.pop_front();
        if (c_rdata !== rd_exp) begin
          miscompares++;
          $display("FAIL c_rdata cyc %0d: got %h expected %h", cyc_no, c_rdata, rd_exp);
        end
      end
    end
    if (d_rvalid) begin
      vectors++;
      if (drd_q.size() == 0) begin
        miscompares++;
        $display("FAIL d_rvalid cyc %0d: got unexpected pulse, expected none", cyc_no);
      end else begin
        rd_exp = drd_q.pop_front();
        if (d_rdata !== rd_exp) begin
          miscompares++;
          $display("FAIL d_rdata cyc %0d: got %h expected %h", cyc_no, d_rdata, rd_exp);
        end
      end
    end
  end

  task automatic set_c(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
    c_req = req; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  // Queue this cycle's expected handshake vector, then advance one clock
  task automatic cyc(input logic [5:0] e);
    cyc_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc_no      = 0;
    rst         = 1'b1;
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("state after reset", 32'(dut.u_fsm.state), 32'(IDLE));
    chk("cnt after reset", 32'(dut.u_fsm.cnt), 32'd0);

    // Core read alone
    set_c(1'b1, 1'b0, 32'h10, 32'h0);
    crd_q.push_back(32'hDEAD_BEEF);
    cyc(6'b100000);
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(6'b000010);
    cyc(6'b000000);
    chk("c_rdata held", c_rdata, 32'hDEAD_BEEF);

    // Reset mid-operation cancels the pending rvalid and clears rdata
    set_c(1'b1, 1'b0, 32'h10, 32'h0);
    cyc(6'b100000);
    rst = 1'b1;
    #1;
    chk("c_rvalid in reset", 32'(c_rvalid), 32'd0);
    chk("c_rdata in reset", c_rdata, 32'h0);
    cyc(6'b001000);
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    chk("state after mid reset", 32'(dut.u_fsm.state), 32'(IDLE));

    // Tie from IDLE, both writes
    set_c(1'b1, 1'b1, 32'h20, 32'h11);
    set_d(1'b1, 1'b1, 32'h24, 32'h22);
    cyc(6'b100100);
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(6'b010100);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(6'b000000);
    chk("mem[0x20]", mem[8], 32'h11);
    chk("mem[0x24]", mem[9], 32'h22);
    chk("d_rdata after write", d_rdata, 32'h0);

    // Burst limit: C streams reads, D waits from cycle 1
    set_c(1'b1, 1'b0, 32'h40, 32'h0);
    crd_q.push_back(32'hA5A5_0010);
    cyc(6'b100000);
    set_d(1'b1, 1'b0, 32'h30, 32'h0);
    set_c(1'b1, 1'b0, 32'h44, 32'h0);
    crd_q.push_back(32'hA5A5_0011);
    cyc(6'b100010);
    set_c(1'b1, 1'b0, 32'h48, 32'h0);
    crd_q.push_back(32'hA5A5_0012);
    cyc(6'b100010);
    set_c(1'b1, 1'b0, 32'h4C, 32'h0);
    crd_q.push_back(32'hA5A5_0013);
    cyc(6'b100010);
    set_c(1'b1, 1'b0, 32'h50, 32'h0);
    drd_q.push_back(32'hA5A5_000C);
    cyc(6'b011010);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    crd_q.push_back(32'hA5A5_0014);
    cyc(6'b100001);
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(6'b000010);
    cyc(6'b000000);

    // Saturation: C alone for 10 cycles, then D write takes over at once
    set_c(1'b1, 1'b0, 32'h40, 32'h0);
    for (int k = 0; k < 10; k++) begin
      crd_q.push_back(32'hA5A5_0010);
      cyc((k == 0) ? 6'b100000 : 6'b100010);
    end
    chk("cnt saturated", 32'(dut.u_fsm.cnt), 32'd4);
    set_d(1'b1, 1'b1, 32'h34, 32'h55);
    cyc(6'b011110);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    crd_q.push_back(32'hA5A5_0010);
    cyc(6'b100000);
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(6'b000010);
    cyc(6'b000000);
    chk("mem[0x34]", mem[13], 32'h55);
    chk("d_rdata kept over write", d_rdata, 32'hA5A5_000C);

    // D read then back-to-back D write
    set_d(1'b1, 1'b0, 32'h44, 32'h0);
    drd_q.push_back(32'hA5A5_0011);
    cyc(6'b010000);
    set_d(1'b1, 1'b1, 32'h38, 32'h77);
    cyc(6'b010101);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(6'b000000);
    chk("d_rdata after d write", d_rdata, 32'hA5A5_0011);
    chk("mem[0x38]", mem[14], 32'h77);

    chk("scoreboard drained", 32'(cyc_q.size() + crd_q.size() + drd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
